// File: rtl/mult_rr_arb.sv
// rtl/mult_rr_arb.sv - round-robin sequencer sharing one multi-cycle signed multiplier among NREQ requesters
// Optional watchdog on the BUSY wait: define MULT_RR_ARB_WDOG_EN.
module mult_rr_arb #(
    parameter int DW       = 32,
    parameter int NREQ     = 4,
    parameter int WDOG_CYC = 256
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       a_in,
    input  logic [NREQ*DW-1:0]       b_in,
    output logic [NREQ-1:0]          gnt,
    output logic [NREQ-1:0]          done,
    output logic [DW-1:0]            res_out,
    output logic [$clog2(NREQ)-1:0]  res_id,
    output logic                     busy,
    output logic                     err,
    output logic                     mul_en,
    output logic [DW-1:0]            mul_a,
    output logic [DW-1:0]            mul_b,
    input  logic                     mul_valid,
    input  logic [DW-1:0]            mul_c
);

    localparam int IDW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 16 || WDOG_CYC < 1) begin : g_param_check
        $error("mult_rr_arb: NREQ must be 2..16 and WDOG_CYC at least 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic [DW-1:0]   res_out_q, res_out_d;
    logic [DW-1:0]   mul_a_q, mul_a_d;
    logic [DW-1:0]   mul_b_q, mul_b_d;
    logic [IDW-1:0]  win;
    logic            found;
    logic [DW-1:0]   win_a, win_b;
    int              idx;

`ifdef MULT_RR_ARB_WDOG_EN
    localparam int CW = $clog2(WDOG_CYC + 1);
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
`endif

    // Search starts just after the last winner, so it has lowest priority next time.
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[IDW'(idx)]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win == IDW'(i)) begin
                win_a = a_in[i*DW +: DW];
                win_b = b_in[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        res_id_d  = res_id_q;
        res_out_d = res_out_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
`ifdef MULT_RR_ARB_WDOG_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LOAD;
                    ptr_d   = win;
                    id_d    = win;
                    mul_a_d = win_a;
                    mul_b_d = win_b;
                end
            end
            S_LOAD: begin
                state_d = S_BUSY;
`ifdef MULT_RR_ARB_WDOG_EN
                cnt_d   = '0;
`endif
            end
            S_BUSY: begin
                if (mul_valid) begin
                    res_out_d = mul_c;
                    res_id_d  = id_q;
                    state_d   = S_DONE;
                end
`ifdef MULT_RR_ARB_WDOG_EN
                else if (cnt_q == CW'(WDOG_CYC - 1)) begin
                    err_d     = 1'b1;
                    res_out_d = '0;
                    res_id_d  = id_q;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            ptr_q     <= IDW'(NREQ - 1);
            id_q      <= '0;
            res_id_q  <= '0;
            res_out_q <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            res_id_q  <= res_id_d;
            res_out_q <= res_out_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
        end
    end

`ifdef MULT_RR_ARB_WDOG_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign gnt     = (state_q == S_LOAD) ? (NREQ'(1) << id_q) : '0;
    assign done    = (state_q == S_DONE) ? (NREQ'(1) << res_id_q) : '0;
    assign mul_en  = (state_q == S_LOAD);
    assign busy    = (state_q != S_IDLE);
    assign mul_a   = mul_a_q;
    assign mul_b   = mul_b_q;
    assign res_out = res_out_q;
    assign res_id  = res_id_q;

endmodule

// File: tb/tb_mult_rr_arb.sv
// tb/tb_mult_rr_arb.sv - self-checking bench for mult_rr_arb with a fixed-latency multiplier model
// Watchdog checks run when MULT_RR_ARB_WDOG_EN is defined.
`timescale 1ns/1ps
module tb_mult_rr_arb;
    localparam int DW   = 32;
    localparam int NREQ = 4;
    localparam int L    = 34;
    localparam int WD   = 16;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*DW-1:0]   a_in = '0;
    logic [NREQ*DW-1:0]   b_in = '0;
    logic [NREQ-1:0]      gnt, done;
    logic [DW-1:0]        res_out;
    logic [1:0]           res_id;
    logic                 busy, err, mul_en;
    logic [DW-1:0]        mul_a, mul_b;
    logic                 mul_valid = 1'b0;
    logic [DW-1:0]        mul_c = '0;

    int checks = 0;
    int errors = 0;
    int ptr_m  = NREQ - 1;
    bit model_on = 1'b1;
    bit stale_en = 1'b0;
    int mcnt = 0;
    logic [DW-1:0] mprod = '0;

    always #5 clk = ~clk;

    mult_rr_arb #(.DW(DW), .NREQ(NREQ), .WDOG_CYC(WD)) dut (
        .clk(clk), .rstn(rstn), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .res_out(res_out), .res_id(res_id),
        .busy(busy), .err(err), .mul_en(mul_en), .mul_a(mul_a), .mul_b(mul_b),
        .mul_valid(mul_valid), .mul_c(mul_c)
    );

    function automatic logic [DW-1:0] prod(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b);
        logic signed [2*DW-1:0] p;
        p = a * b;
        return p[DW-1:0];
    endfunction

    // Multiplier: valid pulse L cycles after the en cycle; optional junk pulse in the en cycle.
    always @(negedge clk or negedge rstn) begin
        if (!rstn) begin
            mcnt      = 0;
            mul_valid = 1'b0;
        end else begin
            mul_valid = 1'b0;
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    mul_valid = 1'b1;
                    mul_c     = mprod;
                end
            end
            if (mul_en) begin
                if (model_on) begin
                    mcnt  = L;
                    mprod = prod(mul_a, mul_b);
                end
                if (stale_en) begin
                    mul_valid = 1'b1;
                    mul_c     = 32'hDEAD_BEEF;
                end
            end
        end
    end

    function automatic int pick(input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int i = (ptr_m + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [NREQ*DW-1:0] rand_ops();
        logic [NREQ*DW-1:0] v;
        for (int i = 0; i < NREQ; i++) v[i*DW +: DW] = $urandom();
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [NREQ-1:0] r, input logic [NREQ*DW-1:0] av,
                            input logic [NREQ*DW-1:0] bv, input bit keep,
                            output int w, output logic [DW-1:0] p);
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_req", busy, 0);
        a_in = av;
        b_in = bv;
        req  = r;
        w    = pick(r);
        p    = prod(av[w*DW +: DW], bv[w*DW +: DW]);
        @(negedge clk);
        check("gnt", gnt, 64'(1) << w);
        check("mul_en", mul_en, 1);
        check("mul_a", mul_a, av[w*DW +: DW]);
        check("mul_b", mul_b, bv[w*DW +: DW]);
        ptr_m = w;
        if (!keep) req[w] = 1'b0;
    endtask

    task automatic finish_op(input int w, input logic [DW-1:0] exp_res, input int min_lat, input int max_lat);
        int lat = 0;
        while (done === '0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("done", done, 64'(1) << w);
        check("res_out", res_out, exp_res);
        check("res_id", res_id, w);
        check("done_latency_ok", (lat >= min_lat && lat <= max_lat), 1);
        stale_en = 1'b0;
    endtask

    initial begin
        int w;
        int dcount;
        logic [DW-1:0] p;
        logic [NREQ*DW-1:0] av, bv;

        repeat (3) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_mul_en", mul_en, 0);
        check("rst_res_out", res_out, 0);
        check("rst_res_id", res_id, 0);
        check("rst_mul_a", mul_a, 0);
        rstn = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // All requesters busy: grants rotate 0..3 twice.
        for (int i = 0; i < 8; i++) begin
            start_op('1, rand_ops(), rand_ops(), 1'b1, w, p);
            check("rr_order", w, i % NREQ);
            finish_op(w, p, L + 1, L + 3);
        end

        // Directed single request: 3 * -5 on requester 2.
        av = '0; bv = '0;
        av[2*DW +: DW] = 32'd3;
        bv[2*DW +: DW] = -32'sd5;
        start_op(4'b0100, av, bv, 1'b0, w, p);
        finish_op(w, -32'sd15, L + 1, L + 3);

        // Pointer continues after the last winner instead of restarting at 0.
        start_op(4'b0010, rand_ops(), rand_ops(), 1'b0, w, p);
        finish_op(w, p, L + 1, L + 3);
        start_op(4'b1010, rand_ops(), rand_ops(), 1'b0, w, p);
        check("ptr_next_is_3", w, 3);
        finish_op(w, p, L + 1, L + 3);
        start_op(4'b0010, rand_ops(), rand_ops(), 1'b0, w, p);
        finish_op(w, p, L + 1, L + 3);

        for (int i = 0; i < 6; i++) begin
            start_op(4'($urandom_range(1, 15)), rand_ops(), rand_ops(), 1'b0, w, p);
            finish_op(w, p, L + 1, L + 3);
        end

        // Junk valid during LOAD must be ignored.
        stale_en = 1'b1;
        start_op(4'($urandom_range(1, 15)), rand_ops(), rand_ops(), 1'b0, w, p);
        finish_op(w, p, L + 1, L + 3);

        // Reset in the middle of BUSY.
        start_op(4'b0100, rand_ops(), rand_ops(), 1'b0, w, p);
        repeat (10) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gnt", gnt, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_res_out", res_out, 0);
        check("mid_rst_mul_a", mul_a, 0);
        check("mid_rst_mul_b", mul_b, 0);
        check("mid_rst_mul_en", mul_en, 0);
        @(negedge clk);
        rstn  = 1'b1;
        req   = '0;
        ptr_m = NREQ - 1;
        dcount = 0;
        for (int i = 0; i < L + 10; i++) begin
            @(negedge clk);
            if (done !== '0) dcount++;
        end
        check("no_done_after_rst", dcount, 0);
        start_op(4'b0011, rand_ops(), rand_ops(), 1'b0, w, p);
        check("post_rst_winner", w, 0);
        finish_op(w, p, L + 1, L + 3);

`ifdef MULT_RR_ARB_WDOG_EN
        model_on = 1'b0;
        start_op(4'b0100, rand_ops(), rand_ops(), 1'b0, w, p);
        finish_op(w, '0, WD + 1, WD + 1);
        check("wdog_err", err, 1);
        model_on = 1'b1;
        start_op(4'b0001, rand_ops(), rand_ops(), 1'b0, w, p);
        finish_op(w, p, L + 1, L + 3);
        check("wdog_err_sticky", err, 1);
`else
        check("err_tied_low", err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
